regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
- Parametrised multi-port integer register file; next generation of the single-write/dual-read core regfile.
- Generalised in data width, register count, read-port count and write-port count.
- Adds two features:
  - same-cycle write-to-read forwarding;
  - an integrated busy scoreboard, so the issue stage can detect RAW hazards on outstanding results.
- Sits between decode/issue and the execute/writeback stages.

Parameters:
- Width, 32, data width of each register in bits.
- NumRegs, 32, architectural register count including hardwired-zero index 0; must be ≥ 2.
- AddrWidth, $clog2(NumRegs), register index width in bits (5 for the default).
- NumRead, 2, number of read ports.
- NumWrite, 1, number of write ports.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- rs  input  NumRead*AddrWidth  read indices; port i occupies bits [i*AddrWidth +: AddrWidth].
- rs_valid  input  NumRead  per-port read enable.
- rw  input  NumWrite*AddrWidth  write indices, packed per port.
- rw_valid  input  NumWrite  per-port write enable.
- wval  input  NumWrite*Width  write data, packed per port.
- rsv  input  AddrWidth  index to mark busy (destination of a newly issued instruction).
- rsv_valid  input  1  reserve enable.
- rd  output  NumRead*Width  registered read data, packed per port.
- rd_busy  output  NumRead  registered busy flag for each read port's index.

Behaviour:
- Storage holds indices 1..NumRegs-1. Index 0:
  - always reads 0 and is never busy;
  - writes and reserves to index 0 are ignored.
- Reset (asynchronous, effective immediately while high):
  - all registers = 0;
  - rd = 0, rd_busy = 0, all busy bits = 0;
  - in-flight reads, writes and reserves in that cycle are discarded.
- Write: on the rising edge, each port w with rw_valid[w]=1 and nonzero rw[w] stores wval[w] into rw[w].
- Multiple write ports targeting the same index in one cycle: the highest-numbered port wins.
- Indices ≥ NumRegs, whether on read, write or reserve:
  - writes and reserves have no effect;
  - reads return 0 with busy = 0.
- Read latency is 1 cycle. If rs_valid[i]=1, then at the edge rd[i] and rd_busy[i] are loaded for index rs[i]. If rs_valid[i]=0, rd[i] and rd_busy[i] hold their previous values.
- Forwarding (write-first):
  - if any write port writes nonzero index X in the same cycle a read of X is enabled, rd[i] takes the winning wval, not the stale storage value;
  - all read ports forward independently.
- Scoreboard: one busy bit per register.
  - A write clears busy[X].
  - rsv_valid with nonzero rsv sets busy[rsv].
  - Reserve and write to the same index in the same cycle: reserve wins, busy stays/becomes 1 (a newer producer is outstanding).
- rd_busy[i] reflects busy[rs[i]] after this edge's write-clear and reserve-set. It is therefore consistent with the forwarded data.
- No handshake back-pressure: all inputs are sampled every cycle. Writes to non-busy registers are legal and simply store.
- Implementation:
  - storage is flops, not an inferred RAM, because of multi-port and forwarding;
  - no combinational path from inputs to rd/rd_busy.

Test Plan:
1. Reset then read: assert reset mid-cycle; rd drops to 0 at once without a clock edge. Release; read rs=5 → rd=0, rd_busy=0.
2. Write/read and x0: write x3=0xDEADBEEF.
   - Next cycle read x3 on port 0 → 0xDEADBEEF one cycle later.
   - Write x0=0x1234, then read x0 → 0.
3. Forwarding and hold:
   - same cycle, write x7=0xA5A5A5A5 and read x7 on ports 0 and 1 → both rd=0xA5A5A5A5 after that edge;
   - drop rs_valid → values held for ≥3 cycles while x7 is rewritten to 0x1.
4. Multi-write priority (NumWrite=2): both ports write x9, port0=0x11 and port1=0x22, with a simultaneous read of x9 → rd=0x22; later read → 0x22.
5. Scoreboard:
   - reserve x4 → read x4 → rd_busy=1;
   - write x4=0x55 → rd_busy=0, rd=0x55;
   - same-cycle reserve and write of x4 → rd_busy=1, rd=new data;
   - reserve x0 → rd_busy=0.
6. Parameter sweep: Width=64, NumRegs=16, NumRead=3, NumWrite=2.
   - random writes/reads/reserves against a reference model for 10k cycles → zero mismatches;
   - index 15 writable;
   - any index ≥ 16 (only reachable when AddrWidth exceeds $clog2(NumRegs)) reads 0.

Source files
------------

// File: rtl/regfile_mp.sv
// regfile_mp -- parametrised multi-port integer register file.
//
// It has NumWrite write ports, NumRead registered read ports, same-cycle
// write-to-read forwarding and a busy scoreboard with one bit per register.
// Index 0 is hardwired to zero and is never busy.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   rs         read indices, port i at [i*AddrWidth +: AddrWidth]
//   rs_valid   per-port read enable (rd/rd_busy hold while low)
//   rw         write indices, packed per port
//   rw_valid   per-port write enable
//   wval       write data, packed per port
//   rsv        index to mark busy (destination of a newly issued op)
//   rsv_valid  reserve enable
//   rd         registered read data, packed per port
//   rd_busy    registered busy flag of each read port's index
module regfile_mp #(
  parameter int Width     = 32,
  parameter int NumRegs   = 32,
  parameter int AddrWidth = $clog2(NumRegs),
  parameter int NumRead   = 2,
  parameter int NumWrite  = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NumRead*AddrWidth-1:0]  rs,
  input  logic [NumRead-1:0]            rs_valid,
  input  logic [NumWrite*AddrWidth-1:0] rw,
  input  logic [NumWrite-1:0]           rw_valid,
  input  logic [NumWrite*Width-1:0]     wval,
  input  logic [AddrWidth-1:0]          rsv,
  input  logic                          rsv_valid,
  output logic [NumRead*Width-1:0]      rd,
  output logic [NumRead-1:0]            rd_busy
);

  // Storage is sized to a power of two so a truncated index always lands
  // inside the array; the entries at and above NumRegs are never written and
  // stay constant zero.
  localparam int          IdxWidth = $clog2(NumRegs);
  localparam int          Depth    = 2 ** IdxWidth;
  localparam logic [31:0] NumRegsU = 32'(NumRegs);

  logic [Width-1:0]         regs_r      [Depth];
  logic [Depth-1:0]         busy_r;
  logic [Width-1:0]         regs_next_s [Depth];
  logic [Depth-1:0]         busy_next_s;
  logic [NumRead*Width-1:0] rd_next_s;
  logic [NumRead-1:0]       rd_busy_next_s;
  logic [AddrWidth-1:0]     widx_s;
  logic [AddrWidth-1:0]     ridx_s;

  // True for an index that names real storage: nonzero and below NumRegs.
  function automatic logic idx_live(input logic [AddrWidth-1:0] idx);
    logic [31:0] wide;
    wide     = 32'(idx);
    idx_live = (idx != {AddrWidth{1'b0}}) && (wide < NumRegsU);
  endfunction

  // Storage slot for an index already known to be live.
  function automatic logic [IdxWidth-1:0] slot(input logic [AddrWidth-1:0] idx);
    slot = idx[IdxWidth-1:0];
  endfunction

  // Post-edge register and scoreboard image: writes in ascending port order
  // so the highest-numbered port wins, then the reserve so that it overrides
  // a same-cycle write clear.
  always_comb begin
    regs_next_s = regs_r;
    busy_next_s = busy_r;
    widx_s      = {AddrWidth{1'b0}};
    for (int w = 0; w < NumWrite; w++) begin
      widx_s = rw[w*AddrWidth +: AddrWidth];
      if (rw_valid[w] && idx_live(widx_s)) begin
        regs_next_s[slot(widx_s)] = wval[w*Width +: Width];
        busy_next_s[slot(widx_s)] = 1'b0;
      end else begin
        // disabled, zero or out-of-range write: image unchanged
      end
    end
    if (rsv_valid && idx_live(rsv)) begin
      busy_next_s[slot(rsv)] = 1'b1;
    end else begin
      // no reserve this cycle
    end
  end

  // Read ports look up the post-edge image, which gives write-first
  // forwarding and a busy flag consistent with the forwarded data.
  always_comb begin
    rd_next_s      = rd;
    rd_busy_next_s = rd_busy;
    ridx_s         = {AddrWidth{1'b0}};
    for (int i = 0; i < NumRead; i++) begin
      ridx_s = rs[i*AddrWidth +: AddrWidth];
      if (rs_valid[i]) begin
        if (idx_live(ridx_s)) begin
          rd_next_s[i*Width +: Width] = regs_next_s[slot(ridx_s)];
          rd_busy_next_s[i]           = busy_next_s[slot(ridx_s)];
        end else begin
          rd_next_s[i*Width +: Width] = {Width{1'b0}};
          rd_busy_next_s[i]           = 1'b0;
        end
      end else begin
        // port idle: hold previous output
      end
    end
  end

  // Register storage and scoreboard state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < Depth; r++) begin
        regs_r[r] <= {Width{1'b0}};
      end
      busy_r <= {Depth{1'b0}};
    end else begin
      regs_r <= regs_next_s;
      busy_r <= busy_next_s;
    end
  end

  // Registered read outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd      <= {(NumRead*Width){1'b0}};
      rd_busy <= {NumRead{1'b0}};
    end else begin
      rd      <= rd_next_s;
      rd_busy <= rd_busy_next_s;
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp in the swept configuration
// (Width=64, NumRegs=16, NumRead=3, NumWrite=2, AddrWidth=5 so that indices
// 16..31 are reachable). A behavioural model of the register file is updated
// at every clock edge and compared with the DUT on every falling edge; the
// directed scenarios also check hand-computed literal values.
module tb_regfile_mp;
  localparam int W   = 64;
  localparam int NR  = 16;
  localparam int AW  = 5;
  localparam int NRD = 3;
  localparam int NWR = 2;

  logic               clk = 1'b0;
  logic               reset;
  logic [NRD*AW-1:0]  rs;
  logic [NRD-1:0]     rs_valid;
  logic [NWR*AW-1:0]  rw;
  logic [NWR-1:0]     rw_valid;
  logic [NWR*W-1:0]   wval;
  logic [AW-1:0]      rsv;
  logic               rsv_valid;
  logic [NRD*W-1:0]   rd;
  logic [NRD-1:0]     rd_busy;

  int n_cmp = 0;
  int n_bad = 0;

  // behavioural model state
  bit [W-1:0] m_reg  [NR];
  bit         m_busy [NR];
  bit [W-1:0] m_rd   [NRD];
  bit         m_rdb  [NRD];

  regfile_mp #(
    .Width    (W),
    .NumRegs  (NR),
    .AddrWidth(AW),
    .NumRead  (NRD),
    .NumWrite (NWR)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .rs       (rs),
    .rs_valid (rs_valid),
    .rw       (rw),
    .rw_valid (rw_valid),
    .wval     (wval),
    .rsv      (rsv),
    .rsv_valid(rsv_valid),
    .rd       (rd),
    .rd_busy  (rd_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int r = 0; r < NR; r++) begin
      m_reg[r]  = '0;
      m_busy[r] = 1'b0;
    end
    for (int i = 0; i < NRD; i++) begin
      m_rd[i]  = '0;
      m_rdb[i] = 1'b0;
    end
  endtask

  // Apply the architectural rules of one clock edge to the model.
  task automatic model_edge();
    bit claimed [NR];
    int x;
    if (reset) begin
      model_clear();
      return;
    end
    // highest-numbered port claims an index first; lower ports lose to it
    for (int w = NWR - 1; w >= 0; w--) begin
      x = int'(rw[w*AW +: AW]);
      if (rw_valid[w] && x != 0 && x < NR && !claimed[x]) begin
        m_reg[x]   = wval[w*W +: W];
        m_busy[x]  = 1'b0;
        claimed[x] = 1'b1;
      end
    end
    x = int'(rsv);
    if (rsv_valid && x != 0 && x < NR) m_busy[x] = 1'b1;
    for (int i = 0; i < NRD; i++) begin
      x = int'(rs[i*AW +: AW]);
      if (rs_valid[i]) begin
        if (x != 0 && x < NR) begin
          m_rd[i]  = m_reg[x];
          m_rdb[i] = m_busy[x];
        end else begin
          m_rd[i]  = '0;
          m_rdb[i] = 1'b0;
        end
      end
    end
  endtask

  // One clock: edge, model update, then return 1 time unit after the edge.
  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic clr();
    rs_valid  = '0;
    rw_valid  = '0;
    rsv_valid = 1'b0;
  endtask

  task automatic wr(input int p, input int idx, input logic [W-1:0] v);
    logic [AW-1:0] a;
    a = idx[AW-1:0];
    rw[p*AW +: AW] = a;
    wval[p*W +: W] = v;
    rw_valid[p]    = 1'b1;
  endtask

  task automatic rdp(input int p, input int idx);
    logic [AW-1:0] a;
    a = idx[AW-1:0];
    rs[p*AW +: AW] = a;
    rs_valid[p]    = 1'b1;
  endtask

  task automatic res(input int idx);
    logic [AW-1:0] a;
    a = idx[AW-1:0];
    rsv       = a;
    rsv_valid = 1'b1;
  endtask

  // Model-vs-DUT compare on every falling edge.
  always @(negedge clk) begin
    for (int i = 0; i < NRD; i++) begin
      n_cmp++;
      if (rd[i*W +: W] !== m_rd[i] || rd_busy[i] !== m_rdb[i]) begin
        n_bad++;
        $display("FAIL model_port%0d t=%0t: got rd=%h busy=%b expected rd=%h busy=%b",
                 i, $time, rd[i*W +: W], rd_busy[i], m_rd[i], m_rdb[i]);
      end
    end
  end

  initial begin
    rs = '0; rw = '0; wval = '0; rsv = '0;
    clr();
    model_clear();
    reset = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;

    // 1: asynchronous reset drops rd immediately, storage cleared
    wr(0, 5, 64'h77);
    cyc();
    clr(); rdp(0, 5);
    cyc();
    check("pre_reset_rd", rd[0 +: W], 64'h77);
    #2;
    reset = 1'b1;
    model_clear();
    #1;
    check("async_reset_rd", rd[0 +: W], 64'h0);
    check("async_reset_busy", {63'h0, rd_busy[0]}, 64'h0);
    cyc();
    reset = 1'b0;
    clr(); rdp(0, 5);
    cyc();
    check("post_reset_rd5", rd[0 +: W], 64'h0);
    check("post_reset_busy5", {63'h0, rd_busy[0]}, 64'h0);

    // 2: write/read and hardwired x0
    clr(); wr(0, 3, 64'hDEADBEEF);
    cyc();
    clr(); rdp(0, 3);
    cyc();
    check("read_x3", rd[0 +: W], 64'hDEADBEEF);
    clr(); wr(0, 0, 64'h1234);
    cyc();
    clr(); rdp(0, 0);
    cyc();
    check("read_x0", rd[0 +: W], 64'h0);

    // 3: forwarding on two ports, then hold while x7 is rewritten
    clr(); wr(0, 7, 64'hA5A5A5A5); rdp(0, 7); rdp(1, 7);
    cyc();
    check("fwd_p0", rd[0 +: W], 64'hA5A5A5A5);
    check("fwd_p1", rd[W +: W], 64'hA5A5A5A5);
    clr(); wr(1, 7, 64'h1);
    for (int k = 0; k < 3; k++) begin
      cyc();
      check("hold_p0", rd[0 +: W], 64'hA5A5A5A5);
      check("hold_p1", rd[W +: W], 64'hA5A5A5A5);
    end
    clr(); rdp(0, 7);
    cyc();
    check("reread_x7", rd[0 +: W], 64'h1);

    // 4: two ports writing the same index, highest port wins
    clr(); wr(0, 9, 64'h11); wr(1, 9, 64'h22); rdp(2, 9);
    cyc();
    check("prio_fwd", rd[2*W +: W], 64'h22);
    clr(); rdp(2, 9);
    cyc();
    check("prio_stored", rd[2*W +: W], 64'h22);

    // 5: scoreboard
    clr(); res(4);
    cyc();
    clr(); rdp(0, 4);
    cyc();
    check("sb_reserved", {63'h0, rd_busy[0]}, 64'h1);
    clr(); wr(0, 4, 64'h55); rdp(0, 4);
    cyc();
    check("sb_write_clear", {63'h0, rd_busy[0]}, 64'h0);
    check("sb_write_data", rd[0 +: W], 64'h55);
    clr(); wr(1, 4, 64'h66); res(4); rdp(0, 4);
    cyc();
    check("sb_rsv_wins", {63'h0, rd_busy[0]}, 64'h1);
    check("sb_rsv_data", rd[0 +: W], 64'h66);
    clr(); res(0); rdp(1, 0);
    cyc();
    check("sb_x0_busy", {63'h0, rd_busy[1]}, 64'h0);

    // 6: top index and out-of-range indices
    clr(); wr(0, 15, 64'hFEDCBA9876543210);
    cyc();
    clr(); rdp(1, 15);
    cyc();
    check("x15_write", rd[W +: W], 64'hFEDCBA9876543210);
    clr(); wr(0, 20, 64'hCAFE); res(20); rdp(2, 20);
    cyc();
    check("oor_rd", rd[2*W +: W], 64'h0);
    check("oor_busy", {63'h0, rd_busy[2]}, 64'h0);

    // randomized traffic
    for (int n = 0; n < 10000; n++) begin
      for (int p = 0; p < NWR; p++) begin
        rw[p*AW +: AW] = AW'($urandom_range(0, 18));
        wval[p*W +: W] = {$urandom, $urandom};
      end
      for (int p = 0; p < NRD; p++) begin
        rs[p*AW +: AW] = ($urandom_range(0, 15) == 0) ? AW'($urandom_range(16, 31))
                                                       : AW'($urandom_range(0, 15));
      end
      rw_valid  = NWR'($urandom);
      rs_valid  = NRD'($urandom);
      rsv       = AW'($urandom_range(0, 17));
      rsv_valid = ($urandom_range(0, 2) == 0);
      cyc();
    end

    clr();
    cyc();
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
